// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
// Multi-channel PWM generator driven by one shared period counter. Each
// channel has debounced increase/decrease buttons feeding a pending duty
// that is copied to the active duty only at the period boundary, so a pulse
// in progress is never cut short or stretched. Channels can be phase
// staggered and the whole block can run edge- or center-aligned.
module pwm_multi_channel #(
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = 4,
   parameter int PERIOD     = 10,
   parameter int DUTY_INIT  = 5,
   parameter int STEP       = 1,
   parameter int DEB_DIV    = 2,
   parameter int PHASE_STEP = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       inc_btn,
   input  logic [CHANNELS-1:0]       dec_btn,
   input  logic                      center_mode,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic [CHANNELS*CNT_W-1:0] duty_act,
   output logic                      period_start
);

   localparam int DEB_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam int DW    = CNT_W + 1;   // duty arithmetic, room for +STEP
   localparam int PW    = CNT_W + 4;   // phase arithmetic, room for offsets

   logic [DEB_W-1:0]    deb_cnt;
   logic                tick;
   logic [CHANNELS-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
   logic [CHANNELS-1:0] inc_press, dec_press;
   logic [CNT_W-1:0]    cnt;
   logic                last_cnt;
   logic                mode_act;
   logic [CHANNELS-1:0] high;

   assign tick      = (deb_cnt == DEB_W'(DEB_DIV - 1));
   assign last_cnt  = (cnt == CNT_W'(PERIOD - 1));
   assign inc_press = inc_s1 & ~inc_s2 & {CHANNELS{tick}};
   assign dec_press = dec_s1 & ~dec_s2 & {CHANNELS{tick}};

   // Debounce tick divider, free-running 0..DEB_DIV-1.
   // NOTE: all clocked state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    deb_cnt <= '0;
      else if (tick) deb_cnt <= '0;
      else           deb_cnt <= deb_cnt + 1'b1;
   end

   // Two-stage button sampler advanced only on ticks; a rising s1/s2 pair is a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_s1 <= '0;
         inc_s2 <= '0;
         dec_s1 <= '0;
         dec_s2 <= '0;
      end else if (tick) begin
         inc_s1 <= inc_btn;
         inc_s2 <= inc_s1;
         dec_s1 <= dec_btn;
         dec_s2 <= dec_s1;
      end
   end

   // Shared period counter, latched mode, and registered channel outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         mode_act     <= 1'b0;
         pwm_out      <= '0;
         period_start <= 1'b0;
      end else begin
         cnt          <= last_cnt ? '0 : cnt + 1'b1;
         pwm_out      <= high;
         period_start <= (cnt == '0);
         if (last_cnt) mode_act <= center_mode;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      // Channel offset reduced once at elaboration so runtime wrap is a single subtract.
      localparam int OFFSET = (i * PHASE_STEP) % PERIOD;

      logic [CNT_W-1:0] duty_next_r, duty_act_r, upd_w;
      logic [DW-1:0]    cur_w, up_w;
      logic [PW-1:0]    sum_w, p_w, d_w, lo_w;

      assign cur_w = {1'b0, duty_next_r};
      assign up_w  = cur_w + DW'(STEP);

      // Saturating pending-duty update; simultaneous inc and dec cancel out.
      // NOTE: upd_w gets its hold value first so no path leaves it unassigned
      // and no latch is inferred.
      always_comb begin
         upd_w = duty_next_r;
         if (inc_press[i] && !dec_press[i])
            upd_w = (up_w > DW'(PERIOD)) ? CNT_W'(PERIOD) : up_w[CNT_W-1:0];
         else if (dec_press[i] && !inc_press[i])
            upd_w = (cur_w < DW'(STEP)) ? '0 : CNT_W'(cur_w - DW'(STEP));
      end

      // Pending duty tracks presses; active duty changes only at the boundary.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty_next_r <= CNT_W'(DUTY_INIT);
            duty_act_r  <= CNT_W'(DUTY_INIT);
         end else begin
            duty_next_r <= upd_w;
            if (last_cnt) duty_act_r <= duty_next_r;
         end
      end

      assign sum_w = PW'(cnt) + PW'(OFFSET);
      assign p_w   = (sum_w >= PW'(PERIOD)) ? (sum_w - PW'(PERIOD)) : sum_w;
      assign d_w   = PW'(duty_act_r);
      assign lo_w  = (PW'(PERIOD) - d_w) >> 1;

      // Edge mode: high for the first d phase slots; center mode: window [lo, lo+d).
      assign high[i] = mode_act ? ((p_w >= lo_w) && (p_w < (lo_w + d_w)))
                                : (p_w < d_w);

      assign duty_act[i*CNT_W +: CNT_W] = duty_act_r;
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel
// Two instances share clock, reset and buttons: dut_a with no phase stagger
// and dut_b with a stagger of 2 counts. A period-level reference model
// predicts outputs from cycle index, active duty and active mode.
module tb_pwm_multi_channel;

   localparam int CH = 4;
   localparam int CW = 4;
   localparam int P  = 10;
   localparam int DI = 5;
   localparam int ST = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [CH-1:0] inc_btn = '0;
   logic [CH-1:0] dec_btn = '0;
   logic center_mode = 1'b0;
   logic [CH-1:0] pwm_a, pwm_b;
   logic ps_a, ps_b;
   logic [CH*CW-1:0] duty_a, duty_b;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt;
   int m_act [CH];
   int m_next [CH];
   logic m_mode;
   logic [CH-1:0] exp_a, exp_b;
   logic exp_ps;

   always #5 clk = ~clk;

   pwm_multi_channel #(.CHANNELS(CH), .CNT_W(CW), .PERIOD(P), .DUTY_INIT(DI),
      .STEP(ST), .DEB_DIV(2), .PHASE_STEP(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .inc_btn(inc_btn), .dec_btn(dec_btn),
      .center_mode(center_mode), .pwm_out(pwm_a), .duty_act(duty_a),
      .period_start(ps_a));

   pwm_multi_channel #(.CHANNELS(CH), .CNT_W(CW), .PERIOD(P), .DUTY_INIT(DI),
      .STEP(ST), .DEB_DIV(2), .PHASE_STEP(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .inc_btn(inc_btn), .dec_btn(dec_btn),
      .center_mode(center_mode), .pwm_out(pwm_b), .duty_act(duty_b),
      .period_start(ps_b));

   // Is channel ch high at period slot c, given stagger ph, duty d and mode?
   function automatic logic want_high(input int c, input int ch, input int ph,
                                      input int d, input logic ctr);
      int p;
      int lo;
      p = (c + ch * ph) % P;
      if (!ctr) return (p < d);
      lo = (P - d) / 2;
      return (p >= lo) && (p < lo + d);
   endfunction

   function automatic logic [CH*CW-1:0] pack_act();
      logic [CH*CW-1:0] v;
      for (int i = 0; i < CH; i++) v[i*CW +: CW] = CW'(m_act[i]);
      return v;
   endfunction

   function automatic logic [CH*CW-1:0] pack_default();
      logic [CH*CW-1:0] v;
      for (int i = 0; i < CH; i++) v[i*CW +: CW] = CW'(DI);
      return v;
   endfunction

   // Model: outputs for slot m_cnt appear one cycle later; duty/mode reload at slot P-1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_mode <= 1'b0;
         exp_a  <= '0;
         exp_b  <= '0;
         exp_ps <= 1'b0;
         for (int i = 0; i < CH; i++) m_act[i] <= DI;
      end else begin
         for (int i = 0; i < CH; i++) begin
            exp_a[i] <= want_high(m_cnt, i, 0, m_act[i], m_mode);
            exp_b[i] <= want_high(m_cnt, i, 2, m_act[i], m_mode);
         end
         exp_ps <= (m_cnt == 0);
         if (m_cnt == P - 1) begin
            m_mode <= center_mode;
            for (int i = 0; i < CH; i++) m_act[i] <= m_next[i];
         end
         m_cnt <= (m_cnt + 1) % P;
      end
   end

   // Cycle-by-cycle scoreboard against the model while out of reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (pwm_a !== exp_a) begin
            errors++;
            $display("FAIL mon_pwm_a t=%0t got %b want %b", $time, pwm_a, exp_a);
         end
         checks++;
         if (pwm_b !== exp_b) begin
            errors++;
            $display("FAIL mon_pwm_b t=%0t got %b want %b", $time, pwm_b, exp_b);
         end
         checks++;
         if (ps_a !== exp_ps || ps_b !== exp_ps) begin
            errors++;
            $display("FAIL mon_period_start t=%0t got %b/%b want %b", $time, ps_a, ps_b, exp_ps);
         end
         checks++;
         if (duty_a !== pack_act() || duty_b !== pack_act()) begin
            errors++;
            $display("FAIL mon_duty t=%0t got %h/%h want %h", $time, duty_a, duty_b, pack_act());
         end
      end
   end

   task automatic wait_cnt(input int c);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_cnt != c && n < 3 * P);
      if (m_cnt != c) begin
         checks++;
         errors++;
         $display("FAIL wait_cnt got %0d want %0d", m_cnt, c);
      end
   endtask

   task automatic apply_press(input logic [CH-1:0] im, input logic [CH-1:0] dm);
      for (int i = 0; i < CH; i++) begin
         if (im[i] && !dm[i])
            m_next[i] = (m_next[i] + ST > P) ? P : m_next[i] + ST;
         else if (dm[i] && !im[i])
            m_next[i] = (m_next[i] < ST) ? 0 : m_next[i] - ST;
      end
   endtask

   // One debounced press: hold 4 cycles from slot t, then release 4 cycles.
   task automatic press(input logic [CH-1:0] im, input logic [CH-1:0] dm, input int t);
      wait_cnt(t);
      inc_btn = im;
      dec_btn = dm;
      repeat (4) @(negedge clk);
      inc_btn = '0;
      dec_btn = '0;
      apply_press(im, dm);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [CH-1:0] want_pwm;
      logic want_ps;
      inc_btn = '0;
      dec_btn = '0;
      center_mode = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      for (int i = 0; i < CH; i++) m_next[i] = DI;
      #1;
      checks++;
      if (pwm_a !== '0 || ps_a !== 1'b0 || duty_a !== pack_default()) begin
         errors++;
         $display("FAIL reset_values got %b %b %h want 0 0 %h", pwm_a, ps_a, duty_a, pack_default());
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      checks++;
      if (pwm_a !== '0 || ps_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_cycle got %b %b want 0 0", pwm_a, ps_a);
      end
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         want_pwm = (((k - 1) % P) < DI) ? '1 : '0;
         want_ps = (((k - 1) % P) == 0);
         checks++;
         if (pwm_a !== want_pwm || ps_a !== want_ps || duty_a !== pack_default()) begin
            errors++;
            $display("FAIL reset_pattern k=%0d got %b %b %h want %b %b %h",
                     k, pwm_a, ps_a, duty_a, want_pwm, want_ps, pack_default());
         end
      end
   endtask

   task automatic test_inc_saturate();
      int want_seq [6] = '{6, 7, 8, 9, 10, 10};
      int prev;
      int hi;
      prev = DI;
      for (int i = 0; i < 6; i++) begin
         press(CH'(1), '0, 1);
         checks++;
         if (duty_a[CW-1:0] !== CW'(prev)) begin
            errors++;
            $display("FAIL inc_before_boundary i=%0d got %0d want %0d", i, duty_a[CW-1:0], prev);
         end
         @(negedge clk);
         checks++;
         if (duty_a[CW-1:0] !== CW'(want_seq[i])) begin
            errors++;
            $display("FAIL inc_after_boundary i=%0d got %0d want %0d", i, duty_a[CW-1:0], want_seq[i]);
         end
         prev = want_seq[i];
      end
      checks++;
      if (duty_a[CH*CW-1:CW] !== {(CH-1){CW'(DI)}}) begin
         errors++;
         $display("FAIL inc_others got %h want all %0d", duty_a[CH*CW-1:CW], DI);
      end
      hi = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         hi += int'(pwm_a[0]);
      end
      checks++;
      if (hi != P) begin
         errors++;
         $display("FAIL inc_full_high got %0d want %0d", hi, P);
      end
   endtask

   task automatic test_dec_floor();
      int want_seq [6] = '{4, 3, 2, 1, 0, 0};
      int hi;
      for (int i = 0; i < 6; i++) begin
         press('0, CH'(2), 1);
         @(negedge clk);
         checks++;
         if (duty_a[2*CW-1:CW] !== CW'(want_seq[i])) begin
            errors++;
            $display("FAIL dec_after_boundary i=%0d got %0d want %0d", i, duty_a[2*CW-1:CW], want_seq[i]);
         end
      end
      hi = 0;
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         hi += int'(pwm_a[1]);
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL dec_full_low got %0d want 0", hi);
      end
      press(CH'(4'b1010), CH'(4'b1010), 1);
      @(negedge clk);
      checks++;
      if (duty_a[2*CW-1:CW] !== CW'(0) || duty_a[4*CW-1:3*CW] !== CW'(DI)) begin
         errors++;
         $display("FAIL simultaneous got %0d,%0d want 0,%0d",
                  duty_a[2*CW-1:CW], duty_a[4*CW-1:3*CW], DI);
      end
   endtask

   task automatic test_mid_period();
      int hi0, hi1;
      hi0 = 0;
      hi1 = 0;
      wait_cnt(1);
      for (int i = 0; i < 2 * P; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) inc_btn = CH'(4'b0100);
         if (i == 5) begin
            inc_btn = '0;
            apply_press(CH'(4'b0100), '0);
         end
         if (i < P) hi0 += int'(pwm_a[2]);
         else       hi1 += int'(pwm_a[2]);
      end
      checks++;
      if (hi0 != 5) begin
         errors++;
         $display("FAIL mid_current_pulse got %0d want 5", hi0);
      end
      checks++;
      if (hi1 != 6) begin
         errors++;
         $display("FAIL mid_next_pulse got %0d want 6", hi1);
      end
   endtask

   task automatic test_phase_center();
      logic [P-1:0] w0, w1, wa;
      for (int i = 0; i < 4; i++) press(CH'(4'b0010), CH'(4'b0001), 1);
      for (int i = 0; i < 2; i++) press('0, CH'(4'b0001), 1);
      wait_cnt(3);
      checks++;
      if (duty_a[2*CW-1:0] !== {CW'(4), CW'(4)}) begin
         errors++;
         $display("FAIL phase_setup got %h want 44", duty_a[2*CW-1:0]);
      end
      center_mode = 1'b1;
      wait_cnt(5);
      checks++;
      if (pwm_a[0] !== 1'b0 || pwm_b[0] !== 1'b0) begin
         errors++;
         $display("FAIL mode_not_yet got %b/%b want 0/0", pwm_a[0], pwm_b[0]);
      end
      wait_cnt(1);
      checks++;
      if (ps_b !== 1'b1) begin
         errors++;
         $display("FAIL phase_period_start got %b want 1", ps_b);
      end
      for (int i = 0; i < P; i++) begin
         if (i > 0) @(negedge clk);
         w0[i] = pwm_b[0];
         w1[i] = pwm_b[1];
         wa[i] = pwm_a[1];
      end
      checks++;
      if (w0 !== 10'h078) begin
         errors++;
         $display("FAIL center_ch0 got %b want %b", w0, 10'h078);
      end
      checks++;
      if (w1 !== 10'h01E) begin
         errors++;
         $display("FAIL phase_ch1_lead got %b want %b", w1, 10'h01E);
      end
      checks++;
      if (wa !== 10'h078) begin
         errors++;
         $display("FAIL no_stagger_ch1 got %b want %b", wa, 10'h078);
      end
   endtask

   task automatic test_random();
      logic [CH-1:0] im, dm;
      for (int r = 0; r < 30; r++) begin
         im = CH'($urandom);
         dm = CH'($urandom);
         if ($urandom_range(0, 3) == 0) center_mode = ~center_mode;
         press(im, dm, int'($urandom_range(0, 5)));
      end
      repeat (2 * P) @(negedge clk);
      checks++;
      if (duty_a !== pack_act()) begin
         errors++;
         $display("FAIL random_final_duty got %h want %h", duty_a, pack_act());
      end
   endtask

   task automatic test_async_reset();
      int n;
      center_mode = 1'b0;
      for (int k = 0; k < 12 && m_next[0] != 8; k++)
         press((m_next[0] < 8) ? CH'(1) : '0, (m_next[0] > 8) ? CH'(1) : '0, 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_cnt == 7 && m_act[0] == 8) && n < 4 * P);
      checks++;
      if (duty_a[CW-1:0] !== CW'(8) || pwm_a[0] !== 1'b1) begin
         errors++;
         $display("FAIL async_setup got duty %0d pwm %b want 8 1", duty_a[CW-1:0], pwm_a[0]);
      end
      #2 rst_n = 1'b0;
      for (int i = 0; i < CH; i++) m_next[i] = DI;
      #1;
      checks++;
      if (pwm_a !== '0 || pwm_b !== '0 || ps_a !== 1'b0 || ps_b !== 1'b0) begin
         errors++;
         $display("FAIL async_outputs got %b %b %b %b want all 0", pwm_a, pwm_b, ps_a, ps_b);
      end
      checks++;
      if (duty_a !== pack_default() || duty_b !== pack_default()) begin
         errors++;
         $display("FAIL async_duty got %h %h want %h", duty_a, duty_b, pack_default());
      end
      test_reset();
   endtask

   initial begin
      for (int i = 0; i < CH; i++) m_next[i] = DI;
      test_reset();
      test_inc_saturate();
      test_dec_floor();
      test_mid_period();
      test_phase_center();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "simulation did not complete");
   end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator with per-channel debounced increase/decrease buttons, glitch-free period-boundary duty updates, optional per-channel phase stagger and selectable edge- or center-aligned mode. It is the generalised successor of the team's single-channel 10-step PWM block. It sits between the board push-buttons and the PWM output pins. A single shared period counter drives all channels.

## Interface
Parameters:
- CHANNELS, 4, number of independent PWM channels (1..8)
- CNT_W, 4, width of period counter and duty registers
- PERIOD, 10, PWM period in clk cycles (2..2^CNT_W-1)
- DUTY_INIT, 5, reset duty for every channel, in counts (0..PERIOD)
- STEP, 1, duty change per accepted button press, in counts
- DEB_DIV, 2, debounce tick divider: tick every DEB_DIV cycles (25000000 on FPGA, 2 in sim)
- PHASE_STEP, 0, phase offset between adjacent channels, in counts (0..PERIOD-1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- inc_btn  in  CHANNELS  raw increase buttons, bit i = channel i
- dec_btn  in  CHANNELS  raw decrease buttons
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  CHANNELS  registered PWM outputs
- duty_act  out  CHANNELS*CNT_W  active duty per channel, channel i at bits [i*CNT_W +: CNT_W]
- period_start  out  1  registered one-cycle pulse at the start of each period

## Operation
- Reset (rst_n low, async): deb_cnt=0, cnt=0, all debounce FFs=0, duty_next=duty_act=DUTY_INIT, mode_act=0, pwm_out=0, period_start=0.
- Tick: deb_cnt counts 0..DEB_DIV-1 and wraps. tick=1 when deb_cnt==DEB_DIV-1.
- Debounce per button: s1<=btn, s2<=s1, both enabled only on tick. press = s1 & ~s2 & tick, one cycle per physical press. A held button produces exactly one press.
- Pending duty, per channel, computed at CNT_W+1 bits:
  - inc press only: duty_next = min(duty_next+STEP, PERIOD).
  - dec press only: duty_next = max(duty_next-STEP, 0).
  - inc and dec presses in the same cycle: no change.
- Period counter: cnt counts 0..PERIOD-1 and wraps.
- Boundary load: in the cycle cnt==PERIOD-1, duty_act<=duty_next for all channels and mode_act<=center_mode. Nothing else changes duty_act or mode_act.
- Phase: p_i = (cnt + i*PHASE_STEP) mod PERIOD. Compute without overflow at CNT_W+4 bits.
- Edge mode: high_i = (p_i < duty_act_i).
- Center mode: lo = (PERIOD - duty_act_i) >> 1. high_i = (lo <= p_i < lo+duty_act_i).
- Both modes keep exactly duty_act_i high cycles per period. Duty 0 gives a constant low; duty PERIOD gives a constant high.
- Outputs: pwm_out[i] <= high_i. period_start <= (cnt==0).

## Timing
- pwm_out and period_start lag cnt by one cycle.
- The first period_start pulse occurs in the 2nd cycle after reset release.
- Button-to-press latency: a button sampled high by s1 on tick k produces press on tick k+1. It must not be released before tick k.
- Press to duty_next: 1 cycle.
- duty_next to duty_act: applied at the next cnt==PERIOD-1 edge.
- duty_act to pwm_out: the new duty is visible from the period beginning 1 cycle later. A mid-period press never shortens or lengthens the current pulse.
- center_mode changes take effect only at the period boundary, with the same timing as duty_act.
- Reset asserted mid-period: all outputs go to their reset values immediately, without waiting for clk. On release, operation restarts from cnt=0.

## Test plan
- Reset check, defaults: release rst_n. Require pwm_out=0 for 1 cycle, then each channel 5 high / 5 low per 10 cycles, all in phase. Require period_start to pulse every 10 cycles and duty_act = 5 on every channel.
- Increase with saturation: on ch0, 6 separate inc presses. Require duty_act0 to step 6,7,8,9,10,10, each change only at a period boundary. At 10, pwm_out[0] is constantly high. Other channels stay at 5.
- Decrease with floor, plus simultaneous press: on ch1, 6 dec presses, requiring duty_act1 to reach 0 and pwm_out[1] to stay constantly low. Then press inc and dec on the same tick: duty is unchanged.
- Mid-period press: press inc at cnt=2 while duty is 5. Require the current pulse to still be 5 cycles and the next period's pulse to be 6 cycles.
- Phase and center mode, with PHASE_STEP=2 and center_mode=1 at duty 4: lo=3, so ch0 is high at p=3..6. Require ch1's high window to lead ch0 by 2 cycles. The mode switch takes effect only at the next period_start.
- Async reset mid-operation: assert rst_n low at cnt=7 with duty 8. Require pwm_out=0 and duty_act=5 before the next clk edge. After release, repeat the reset check.
